// File: rtl/tl_ul_initiator.sv
// rtl/tl_ul_initiator.sv - single-outstanding TileLink-UL initiator; optional D-wait timeout via TL_TIMEOUT_EN
module tl_ul_initiator #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 128,
  parameter logic [2:0]  SRC_ID = 3'd0,
  parameter int unsigned TMO    = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [AW-1:0]   req_addr,
  input  logic [7:0]      req_size,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wmask,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            a_valid,
  input  logic            a_ready,
  output logic [2:0]      a_opcode,
  output logic [2:0]      a_param,
  output logic [7:0]      a_size,
  output logic [2:0]      a_source,
  output logic [AW-1:0]   a_address,
  output logic [DW/8-1:0] a_mask,
  output logic [DW-1:0]   a_data,
  output logic            a_corrupt,
  input  logic            d_valid,
  output logic            d_ready,
  input  logic [2:0]      d_opcode,
  input  logic [1:0]      d_param,
  input  logic [7:0]      d_size,
  input  logic [2:0]      d_source,
  input  logic [2:0]      d_sink,
  input  logic            d_denied,
  input  logic [DW-1:0]   d_data,
  input  logic            d_corrupt
);
  localparam int unsigned MW  = DW / 8;
  localparam int unsigned LGM = $clog2(MW);

  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, RSP} state_t;

  state_t state_q, state_d;
  logic   wen_q;
  logic   tmo_hit;

  logic          size_ok, req_bad, full_mask;
  int unsigned   nbytes, off;
  logic [MW-1:0] win;
  logic [2:0]    req_opcode;
  logic [MW-1:0] req_mask;

  // Fields TileLink defines but this initiator has no use for.
  logic unused_d_fields;
  assign unused_d_fields = ^{d_param, d_size, d_sink};

  assign req_ready = (state_q == IDLE);
  assign a_valid   = (state_q == A_SEND);
  assign d_ready   = (state_q == D_WAIT);
  assign rsp_valid = (state_q == RSP);
  assign a_param   = 3'd0;
  assign a_source  = SRC_ID;
  assign a_corrupt = 1'b0;

  // Byte window addressed by the request decides opcode and lane mask.
  always_comb begin
    size_ok = (req_size <= 8'(LGM));
    nbytes  = size_ok ? (32'd1 << req_size) : 32'd0;
    off     = 32'(req_addr[LGM-1:0]);
    req_bad = !size_ok || ((req_addr & AW'(nbytes - 32'd1)) != '0);
    win     = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      win[i] = (i >= off) && (i < off + nbytes);
    end
    full_mask  = ((req_wmask & win) == win);
    req_opcode = !req_wen ? 3'd4 : (full_mask ? 3'd0 : 3'd1);
    req_mask   = (!req_wen || full_mask) ? win : (req_wmask & win);
  end

`ifdef TL_TIMEOUT_EN
  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state_q == A_SEND) begin
      tmo_cnt <= '0;
    end else if (state_q == D_WAIT) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = (state_q == D_WAIT) && !d_valid && (tmo_cnt == TW'(TMO - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = req_bad ? RSP : A_SEND;
      A_SEND:  if (a_ready) state_d = D_WAIT;
      D_WAIT:  if (d_valid || tmo_hit) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q     <= 1'b0;
      a_opcode  <= 3'd0;
      a_size    <= 8'd0;
      a_address <= '0;
      a_mask    <= '0;
      a_data    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        wen_q <= req_wen;
        if (req_bad) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          a_opcode  <= req_opcode;
          a_size    <= req_size;
          a_address <= req_addr;
          a_mask    <= req_mask;
          a_data    <= req_wen ? req_wdata : '0;
        end
      end
      if (state_q == D_WAIT && d_valid) begin
        rsp_err   <= d_denied | d_corrupt | (d_source != SRC_ID) |
                     (wen_q ? (d_opcode != 3'd0) : (d_opcode != 3'd1));
        rsp_rdata <= wen_q ? '0 : d_data;
      end else if (tmo_hit) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule
